// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared types and constants for the I2C register target.
//               Holds the protocol FSM state encoding, the ACK/NACK line
//               levels and the width of the per-byte bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_WAIT_RD   = 4'd9
    } i2c_state_e;

    // SDA levels during the acknowledge bit
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    // Bit counter runs 0..8 (eight data bits, then the ACK bit)
    localparam int                   BIT_CNT_W    = 4;
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST = 4'd8;

    function automatic logic [BIT_CNT_W-1:0] bit_cnt_next(input logic [BIT_CNT_W-1:0] cnt);
        return (cnt == BIT_CNT_LAST) ? '0 : cnt + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// ============================================================================
// Module      : i2c_bus_sync
// Description : Brings the raw SCL/SDA pins into the clk domain and derives
//               SCL rise/fall and START/STOP conditions from the
//               synchronised samples.
// Ports       : clk, rst_n        - system clock, async active-low reset
//               scl_i, sda_i      - raw bus pins
//               sda               - synchronised SDA level
//               scl_rise/scl_fall - one-cycle SCL edge strobes
//               start_det         - SDA fell while SCL high
//               stop_det          - SDA rose while SCL high
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic                   scl_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda   = sda_sync_q[SYNC_STAGES-1];

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        scl_prev_d = scl_s;
        sda_prev_d = sda;
    end

    // Reset to all ones: an idle bus has both lines high, so no false
    // edges are seen when reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign scl_rise  =  scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s &  scl_prev_q;
    // SCL must be high on both samples so an SDA change that coincides
    // with an SCL edge is never taken for START/STOP.
    assign start_det = scl_s & scl_prev_q &  sda_prev_q & ~sda;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q &  sda;

endmodule
`default_nettype wire

// File: rtl/i2c_target_regs.sv
`default_nettype none
// ============================================================================
// Module      : i2c_target_regs
// Description : I2C target exposing a byte-addressed register space.
//               A write transaction loads the pointer with the first byte and
//               writes following bytes at auto-incrementing addresses. A read
//               transaction returns bytes from the pointer onwards.
// Ports       : clk, rst_n              - system clock, async active-low reset
//               scl_i, sda_i            - raw bus pins
//               scl_oe, sda_oe          - 1 pulls the line low
//               mem_addr/wdata/we       - one-cycle write strobe
//               mem_re/rdata/rvalid     - one-cycle read request and return
//               busy                    - between START and STOP
//               nack_seen               - pulse on controller NACK of a read
// Config      : I2C_TARGET_CLK_STRETCH_EN - hold SCL low in WAIT_RD until
//               mem_rvalid. Undefined: scl_oe tied low, read data captured
//               one clk after mem_re.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         DEPTH       = 16,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     scl_oe,
    output logic                     sda_oe,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [7:0]               mem_wdata,
    output logic                     mem_we,
    output logic                     mem_re,
    input  logic [7:0]               mem_rdata,
    input  logic                     mem_rvalid,
    output logic                     busy,
    output logic                     nack_seen
);

    localparam int PW = $clog2(DEPTH);

    logic sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_e           state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic                 rw_q, rw_d;
    logic                 sda_oe_q, sda_oe_d;
    logic [PW-1:0]        mem_addr_q, mem_addr_d;
    logic [7:0]           mem_wdata_q, mem_wdata_d;
    logic                 mem_we_q, mem_we_d;
    logic                 mem_re_q, mem_re_d;
    logic                 nack_seen_q, nack_seen_d;
    logic                 busy_q, busy_d;
    logic                 issue_rd;
    logic                 rd_capture;
    logic [PW-1:0]        ptr_inc;
    logic [PW-1:0]        ptr_load;

    // Explicit wrap so non-power-of-two depths stay inside 0..DEPTH-1
    assign ptr_inc  = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    assign ptr_load = PW'({24'd0, shift_q} % 32'(DEPTH));

`ifdef I2C_TARGET_CLK_STRETCH_EN
    logic scl_oe_q, scl_oe_d;

    assign rd_capture = (state_q == ST_WAIT_RD) && mem_rvalid;
    assign scl_oe     = scl_oe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) scl_oe_q <= 1'b0;
        else        scl_oe_q <= scl_oe_d;
    end
`else
    // Fixed-latency memory: data is present the cycle after mem_re
    logic rd_pend_q, rd_pend_d;
    logic unused_rvalid;

    assign rd_pend_d     = mem_re_q;
    assign rd_capture    = (state_q == ST_WAIT_RD) && rd_pend_q;
    assign scl_oe        = 1'b0;
    assign unused_rvalid = mem_rvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_pend_q <= 1'b0;
        else        rd_pend_q <= rd_pend_d;
    end
`endif

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        nack_seen_d = 1'b0;
        busy_d      = busy_q;
        issue_rd    = 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
        scl_oe_d    = scl_oe_q;
`endif

        if (start_det || stop_det) begin
            // Bus conditions override everything, including a partial byte
            state_d   = start_det ? ST_ADDR : ST_IDLE;
            busy_d    = start_det;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
            scl_oe_d  = 1'b0;
`endif
        end else begin
            if (scl_rise && (state_q != ST_IDLE) && (state_q != ST_WAIT_RD)) begin
                bit_cnt_d = bit_cnt_next(bit_cnt_q);
            end

            case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda};
                    end
                    // Falling edge after the 8th bit: byte complete, drive ACK
                    if (scl_fall && (bit_cnt_q == BIT_CNT_LAST)) begin
                        sda_oe_d = 1'b1;
                        if (state_q == ST_ADDR) begin
                            if (shift_q[7:1] == TARGET_ADDR) begin
                                rw_d    = shift_q[0];
                                state_d = ST_ADDR_ACK;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = ST_IDLE;
                            end
                        end else if (state_q == ST_PTR) begin
                            ptr_d   = ptr_load;
                            state_d = ST_PTR_ACK;
                        end else begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = ptr_q;
                            mem_wdata_d = shift_q;
                            ptr_d       = ptr_inc;
                            state_d     = ST_WDATA_ACK;
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        if (rw_q) issue_rd = 1'b1;
                        else      state_d  = ST_PTR;
                    end
                end

                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_WDATA;
                    end
                end

                ST_WAIT_RD: begin
                    // SCL is low here, so the first data bit goes straight out
                    if (rd_capture) begin
                        shift_d   = mem_rdata;
                        sda_oe_d  = ~mem_rdata[7];
                        bit_cnt_d = '0;
                        state_d   = ST_RDATA;
`ifdef I2C_TARGET_CLK_STRETCH_EN
                        scl_oe_d  = 1'b0;
`endif
                    end
                end

                ST_RDATA: begin
                    if (scl_fall && (bit_cnt_q != '0)) begin
                        if (bit_cnt_q == BIT_CNT_LAST) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RDATA_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end

                ST_RDATA_ACK: begin
                    if (scl_rise && (sda == I2C_NACK)) begin
                        // Controller is done; idle until START/STOP
                        nack_seen_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else if (scl_fall) begin
                        issue_rd = 1'b1;
                    end
                end

                default: begin
                end
            endcase

            if (issue_rd) begin
                mem_re_d   = 1'b1;
                mem_addr_d = ptr_q;
                ptr_d      = ptr_inc;
                state_d    = ST_WAIT_RD;
`ifdef I2C_TARGET_CLK_STRETCH_EN
                scl_oe_d   = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            nack_seen_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            nack_seen_q <= nack_seen_d;
            busy_q      <= busy_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign busy      = busy_q;
    assign nack_seen = nack_seen_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_target_regs
// Description : Directed bench for i2c_target_regs. A bit-banged controller
//               drives open-drain SCL/SDA; a small memory model answers
//               reads; monitors record strobes for later comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_target_regs;

    localparam int Q_CLK = 8;   // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl_ctrl, sda_ctrl;
    logic       scl_line, sda_line;
    logic       scl_oe, sda_oe;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we, mem_re;
    logic [7:0] mem_rdata  = 8'h00;
    logic       mem_rvalid = 1'b0;
    logic       busy, nack_seen;

    assign scl_line = scl_ctrl & ~scl_oe;
    assign sda_line = sda_ctrl & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_regs #(
        .TARGET_ADDR (7'h50),
        .DEPTH       (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_i      (scl_line),
        .sda_i      (sda_line),
        .scl_oe     (scl_oe),
        .sda_oe     (sda_oe),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .busy       (busy),
        .nack_seen  (nack_seen)
    );

    // ---------------- memory model ----------------
    logic [7:0] mem [0:15];
`ifdef I2C_TARGET_CLK_STRETCH_EN
    int         dly = 0;
    logic [3:0] lat_addr = 4'd0;
    always @(posedge clk) begin
        mem_rvalid <= 1'b0;
        if (mem_re) begin
            dly      <= 50;
            lat_addr <= mem_addr;
        end else if (dly != 0) begin
            dly <= dly - 1;
            if (dly == 1) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= mem[lat_addr];
            end
        end
    end
`else
    always @(posedge clk) begin
        mem_rvalid <= mem_re;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end
`endif

    // ---------------- monitors ----------------
    int         we_cnt = 0, re_cnt = 0, nack_cnt = 0;
    int         sda_oe_cycles = 0, scl_oe_cycles = 0;
    logic [3:0] we_addr [0:15];
    logic [7:0] we_data [0:15];
    logic [3:0] re_addr [0:15];

    always @(negedge clk) begin
        if (mem_we && we_cnt < 16) begin
            we_addr[we_cnt] <= mem_addr;
            we_data[we_cnt] <= mem_wdata;
        end
        if (mem_re && re_cnt < 16) re_addr[re_cnt] <= mem_addr;
        if (mem_we)    we_cnt        <= we_cnt + 1;
        if (mem_re)    re_cnt        <= re_cnt + 1;
        if (nack_seen) nack_cnt      <= nack_cnt + 1;
        if (sda_oe)    sda_oe_cycles <= sda_oe_cycles + 1;
        if (scl_oe)    scl_oe_cycles <= scl_oe_cycles + 1;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int timeouts = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- controller ----------------
    task automatic qwait();
        repeat (Q_CLK) @(posedge clk);
        #2;
    endtask

    task automatic scl_release();
        int n;
        n = 0;
        scl_ctrl = 1'b1;
        while (scl_line !== 1'b1 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (scl_line !== 1'b1) timeouts++;
    endtask

    task automatic bus_start();
        sda_ctrl = 1'b1; qwait();
        scl_release();   qwait();
        sda_ctrl = 1'b0; qwait();
        scl_ctrl = 1'b0; qwait();
    endtask

    task automatic bus_stop();
        sda_ctrl = 1'b0; qwait();
        scl_release();   qwait();
        sda_ctrl = 1'b1; qwait();
    endtask

    task automatic write_bit(input logic b);
        sda_ctrl = b;    qwait();
        scl_release();   qwait(); qwait();
        scl_ctrl = 1'b0; qwait();
    endtask

    task automatic read_bit(output logic b);
        sda_ctrl = 1'b1; qwait();
        scl_release();   qwait();
        b = sda_line;    qwait();
        scl_ctrl = 1'b0; qwait();
    endtask

    task automatic write_byte(input logic [7:0] data, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(data[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] data, input logic ack_bit);
        logic b;
        data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            data = {data[6:0], b};
        end
        write_bit(ack_bit);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic       ack;
        logic       b;
        logic [7:0] rd0, rd1;
        int         sda_before;

        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0] = 8'h96;
        mem[5] = 8'hA5;
        mem[6] = 8'h3C;

        rst_n    = 1'b0;
        scl_ctrl = 1'b1;
        sda_ctrl = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        chk("rst_sda_oe",    sda_oe,    1'b0);
        chk("rst_scl_oe",    scl_oe,    1'b0);
        chk("rst_mem_we",    mem_we,    1'b0);
        chk("rst_mem_re",    mem_re,    1'b0);
        chk("rst_busy",      busy,      1'b0);
        chk("rst_nack_seen", nack_seen, 1'b0);
        chk("rst_mem_addr",  mem_addr,  4'd0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #2;

        // Write ptr 3, data 0x11 0x22
        bus_start();
        chk("busy_after_start", busy, 1'b1);
        write_byte(8'hA0, ack); chk("w1_addr_ack", ack, 1'b0);
        write_byte(8'h03, ack); chk("w1_ptr_ack",  ack, 1'b0);
        write_byte(8'h11, ack); chk("w1_d0_ack",   ack, 1'b0);
        write_byte(8'h22, ack); chk("w1_d1_ack",   ack, 1'b0);
        bus_stop();
        qwait();
        chk("busy_after_stop", busy,       1'b0);
        chk("w1_we_cnt",       we_cnt,     2);
        chk("w1_we0_addr",     we_addr[0], 4'd3);
        chk("w1_we0_data",     we_data[0], 8'h11);
        chk("w1_we1_addr",     we_addr[1], 4'd4);
        chk("w1_we1_data",     we_data[1], 8'h22);

        // Pointer wrap: ptr 15, data 0xAA 0xBB
        bus_start();
        write_byte(8'hA0, ack); chk("w2_addr_ack", ack, 1'b0);
        write_byte(8'h0F, ack); chk("w2_ptr_ack",  ack, 1'b0);
        write_byte(8'hAA, ack); chk("w2_d0_ack",   ack, 1'b0);
        write_byte(8'hBB, ack); chk("w2_d1_ack",   ack, 1'b0);
        bus_stop();
        qwait();
        chk("w2_we_cnt",   we_cnt,     4);
        chk("w2_we2_addr", we_addr[2], 4'd15);
        chk("w2_we2_data", we_data[2], 8'hAA);
        chk("w2_we3_addr", we_addr[3], 4'd0);
        chk("w2_we3_data", we_data[3], 8'hBB);

        // Set ptr 5, repeated START, read two bytes (ACK, NACK)
        bus_start();
        write_byte(8'hA0, ack); chk("r1_waddr_ack", ack, 1'b0);
        write_byte(8'h05, ack); chk("r1_ptr_ack",   ack, 1'b0);
        bus_start();
        write_byte(8'hA1, ack); chk("r1_raddr_ack", ack, 1'b0);
        read_byte(rd0, 1'b0);
        read_byte(rd1, 1'b1);
        bus_stop();
        qwait();
        chk("r1_byte0",    rd0,        8'hA5);
        chk("r1_byte1",    rd1,        8'h3C);
        chk("r1_re_cnt",   re_cnt,     2);
        chk("r1_re0_addr", re_addr[0], 4'd5);
        chk("r1_re1_addr", re_addr[1], 4'd6);
        chk("r1_nack_cnt", nack_cnt,   1);
        chk("r1_we_cnt",   we_cnt,     4);
        chk("r1_busy",     busy,       1'b0);

        // Foreign address: no ACK, no drive, no strobes
        sda_before = sda_oe_cycles;
        bus_start();
        write_byte(8'hA2, ack); chk("x_addr_nack", ack, 1'b1);
        write_byte(8'h07, ack); chk("x_data_nack", ack, 1'b1);
        bus_stop();
        qwait();
        chk("x_sda_oe_cycles", sda_oe_cycles - sda_before, 0);
        chk("x_we_cnt",        we_cnt, 4);
        chk("x_re_cnt",        re_cnt, 2);

        // Reset while the target drives a read data bit low
        bus_start();
        write_byte(8'hA0, ack); chk("rr_waddr_ack", ack, 1'b0);
        write_byte(8'h05, ack); chk("rr_ptr_ack",   ack, 1'b0);
        bus_start();
        write_byte(8'hA1, ack); chk("rr_raddr_ack", ack, 1'b0);
        read_bit(b);            chk("rr_bit7",      b,   1'b1);
        chk("rr_pre_sda_oe", sda_oe, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rr_sda_oe", sda_oe, 1'b0);
        chk("rr_scl_oe", scl_oe, 1'b0);
        chk("rr_busy",   busy,   1'b0);
        scl_ctrl = 1'b1;
        sda_ctrl = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        chk("rr_re_cnt_pre", re_cnt, 3);
        bus_start();
        write_byte(8'hA1, ack); chk("rr2_raddr_ack", ack, 1'b0);
        read_byte(rd0, 1'b1);
        bus_stop();
        qwait();
        chk("rr2_byte",    rd0,        8'h96);
        chk("rr2_re_cnt",  re_cnt,     4);
        chk("rr2_re_addr", re_addr[3], 4'd0);
        chk("rr2_we_cnt",  we_cnt,     4);
        chk("rr2_nack",    nack_cnt,   2);

`ifdef I2C_TARGET_CLK_STRETCH_EN
        // Four reads, each holding SCL for about 52 cycles
        chk("stretch_cycles_in_range",
            32'((scl_oe_cycles >= 200) && (scl_oe_cycles <= 220)), 1);
`else
        chk("scl_oe_never", scl_oe_cycles, 0);
`endif
        chk("scl_timeouts", timeouts, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_target_regs.md
I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 SHALL have parameter TARGET_ADDR, default 7'h50, 7-bit bus address answered.
REQ-002 SHALL have parameter DEPTH, default 16, number of byte locations (2..256); pointer width PW = clog2(DEPTH).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth on scl/sda inputs (>=2).
REQ-004 SHALL have ports: clk in 1 system clock (>=10x SCL); rst_n in 1 reset, asynchronous, active-low.
REQ-005 SHALL have ports scl_i in 1, sda_i in 1: raw bus pins.
REQ-006 SHALL have ports scl_oe out 1, sda_oe out 1: 1 pulls the line low; 0 releases it.
REQ-007 SHALL have ports mem_addr out PW, mem_wdata out 8, mem_we out 1: one-cycle write strobe.
REQ-008 SHALL have ports mem_re out 1: one-cycle read request; mem_rdata in 8; mem_rvalid in 1: read data valid.
REQ-009 SHALL have ports busy out 1: high between START and STOP; nack_seen out 1: one-cycle pulse on a controller NACK.

Function
REQ-010 SHALL synchronise scl_i/sda_i in clk domain; SCL rise/fall and START/STOP are detected from synchronised edges.
REQ-011 START: SDA fall while SCL high; STOP: SDA rise while SCL high; each SHALL force state ADDR or IDLE from any state, including mid-byte.
REQ-012 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_RD.
REQ-013 Bits SHALL be sampled on SCL rise, MSB first; bit count 0..8 wraps to 0 after the ACK bit.
REQ-014 ADDR: on a 7-bit match, SHALL ACK (sda_oe=1 from SCL fall after bit 8 until next SCL fall); on mismatch, SHALL release the bus and return to IDLE.
REQ-015 Write (R/W=0): first byte SHALL load the pointer modulo DEPTH; later bytes SHALL each produce one mem_we pulse at the ACK-driving SCL fall, with mem_addr=pointer, followed by pointer increment.
REQ-016 Read (R/W=1): mem_re SHALL pulse at the pointer immediately after address ACK and after each controller ACK; returned byte is shifted out MSB first, with sda_oe=~bit changing only on SCL fall.
REQ-017 Pointer SHALL wrap from DEPTH-1 to 0; SHALL persist across transactions; repeated START keeps it.
REQ-018 Controller NACK (SDA high at RDATA_ACK SCL rise) SHALL pulse nack_seen, release sda, and wait for START/STOP; no further mem_re.
REQ-019 sda_oe SHALL never change while synchronised SCL is high, except release on START/STOP.

Reset
REQ-020 rst_n low SHALL set state IDLE, pointer 0, all outputs 0, synchronisers to 1 (idle bus).
REQ-021 Reset mid-transaction SHALL release both lines within the same clk edge; no mem_we afterwards.

Configuration
REQ-022 Macro I2C_TARGET_CLK_STRETCH_EN defined: in WAIT_RD, scl_oe=1 from SCL fall until mem_rvalid, then release; mem_rvalid may arrive any number of cycles later.
REQ-023 Macro undefined: scl_oe tied 0; mem_rdata SHALL be captured exactly 1 clk after mem_re, with mem_rvalid ignored.

Structure
REQ-024 Package i2c_pkg SHALL hold the state enum, I2C_ACK/I2C_NACK constants, and bit-count width.
REQ-025 Sub-module i2c_bus_sync SHALL hold synchronisers and START/STOP/edge detection.

Verification
REQ-026 Write 0xA0, ptr 0x03, data 0x11,0x22, STOP -> mem_we at addr 3=0x11, 4=0x22; two data ACKs; busy low after STOP.
REQ-027 Write ptr 0x0F, data 0xAA,0xBB with DEPTH=16 -> writes at 15 then 0 (wrap).
REQ-028 Write ptr 0x05, Sr, 0xA1, read 2 bytes ACK then NACK -> mem_re at 5,6; bytes shifted correctly; nack_seen pulses once.
REQ-029 Address 0xA2 -> no ACK, sda_oe stays 0, no mem strobes.
REQ-030 STRETCH_EN with mem_rvalid delayed 50 clk -> scl_oe high until rvalid; without macro, scl_oe stays 0.
REQ-031 rst_n asserted mid-data-byte -> sda_oe=0, scl_oe=0 immediately; pointer 0.
